shiftreg_blkbuf: RTL

SHIFTREG_BLKBUF -- requirements
Module: shiftreg_blkbuf

---
 rtl/shiftreg_blkbuf_pkg.sv | 19 +
 rtl/shiftreg_core.sv | 23 ++
 rtl/shiftreg_blkbuf.sv | 103 ++++++++++
 3 files changed

// File: rtl/shiftreg_blkbuf_pkg.sv
// Shared defaults, FSM state encoding and block-length constants for the
// block-assembling shift register.
package shiftreg_blkbuf_pkg;

  localparam int W_DEF        = 8;
  localparam int MAX_BITS_DEF = 6144;
  localparam int MIN_BITS_DEF = 1056;

  // Words per block at the default geometry.
  localparam int MAX_WORDS_DEF = MAX_BITS_DEF / W_DEF;
  localparam int MIN_WORDS_DEF = MIN_BITS_DEF / W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/shiftreg_core.sv
// W-wide right-shifting storage; new words enter at the top, so the oldest
// word of a block ends up in the lowest bits.
module shiftreg_core #(
  parameter int W = 8,
  parameter int N = 6144
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] shiftin,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n || clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {shiftin, q[N-1:W]};
    end
  end

endmodule

// File: rtl/shiftreg_blkbuf.sv
// Block buffer: collects a large or small block of words into a shift
// register, holds it stable while full and releases it on out_ack.
module shiftreg_blkbuf
  import shiftreg_blkbuf_pkg::*;
#(
  parameter  int W        = W_DEF,
  parameter  int MAX_BITS = MAX_BITS_DEF,
  parameter  int MIN_BITS = MIN_BITS_DEF,
  localparam int CW       = $clog2(MAX_BITS / W + 1)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                flush,
  input  logic                size_sel,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  input  logic                out_ack,
  output logic                blk_full,
  output logic                blk_small,
  output logic [CW-1:0]       fill_cnt,
  output logic [MAX_BITS-1:0] q_max,
  output logic [MIN_BITS-1:0] q_min,
  output logic [W-1:0]        shiftout
);

  localparam int             MAX_WORDS = MAX_BITS / W;
  localparam int             MIN_WORDS = MIN_BITS / W;
  localparam logic [CW-1:0]  MAX_TGT   = CW'(MAX_WORDS);
  localparam logic [CW-1:0]  MIN_TGT   = CW'(MIN_WORDS);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt, cnt_inc, tgt;
  logic          small_r, small_nxt, tgt_small, accept;

  assign in_ready = (state != FULL);
  // A word arriving alongside flush is dropped rather than shifted in.
  assign accept   = in_valid && in_ready && !flush;

  // The size is taken live from size_sel only for the first word of a block.
  assign tgt_small = (state == IDLE) ? size_sel : small_r;
  assign tgt       = tgt_small ? MIN_TGT : MAX_TGT;
  assign cnt_inc   = cnt_r + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_r;
    small_nxt = small_r;
    case (state)
      IDLE: begin
        if (accept) begin
          small_nxt = size_sel;
          cnt_nxt   = CW'(1);
          state_nxt = (tgt == CW'(1)) ? FULL : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == tgt) state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      state   <= IDLE;
      cnt_r   <= '0;
      small_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_r   <= cnt_nxt;
      small_r <= small_nxt;
    end
  end

  shiftreg_core #(
    .W (W),
    .N (MAX_BITS)
  ) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .clr      (flush),
    .shift_en (accept),
    .shiftin  (in_data),
    .q        (q_max)
  );

  assign blk_full  = (state == FULL);
  assign blk_small = small_r;
  assign fill_cnt  = cnt_r;
  assign q_min     = q_max[MAX_BITS-1 -: MIN_BITS];
  assign shiftout  = q_max[W-1:0];

endmodule
